pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-level sequencer for the pong datapath, running on the 60 Hz frame clock. It owns the match state machine, the player scores, the serve timing and the serve direction. It drives the ball block's `state` input and its run/hold controls, and consumes one-frame point pulses from the ball's boundary logic. Ball motion, paddle collision and angle selection stay in the ball block; this block decides only when the ball moves, when it is recentred and when the match ends.

## Interface
Parameters:
- `WIN_SCORE`, 4'd7: score that ends the match; legal range 1..15.
- `SERVE_DELAY`, 8'd60: frames held centred before each serve; legal range 1..255.
- `POINT_PAUSE`, 8'd30: frames frozen after a point; legal range 1..255.

Ports:
- `sixtyhz_clk`, in, 1: frame clock; every register in this block is clocked on its rising edge.
- `resetn`, in, 1: synchronous, active-low.
- `start_btn`, in, 1: level, already synchronised; its rising edge is the action.
- `pause_btn`, in, 1: level, already synchronised; its rising edge is the action.
- `p1_point`, in, 1: one-frame pulse; ball left the right edge, so p1 (left paddle) scores.
- `p2_point`, in, 1: one-frame pulse; ball left the left edge, so p2 scores.
- `state`, out, 3: current state encoding; connects to the ball block's `state` input.
- `ball_run`, out, 1: ball moves this frame.
- `ball_hold_center`, out, 1: ball forced to (80,75).
- `serve_dir_x`, out, 1: 0 = serve toward +x (p2), 1 = toward −x (p1).
- `p1_score`, out, 4: registered score for p1.
- `p2_score`, out, 4: registered score for p2.
- `winner`, out, 2: 0 none, 1 p1, 2 p2.

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5. Codes 6 and 7 recover to IDLE on the next frame.
- Edge detection: `start_e` = `start_btn` & ~`start_q`; `pause_e` is formed the same way from `pause_btn`. `start_q` and `pause_q` reset to 1, so a button held through reset produces no edge.
- IDLE: on `start_e`, clear both scores and `winner`, set `serve_dir_x`=0, go to SERVE.
- SERVE: load `timer`=`SERVE_DELAY`−1 on entry and decrement each frame. When `timer`==0, go to PLAY.
- PLAY:
  - `p1_point` alone: `p1_score`+1, `serve_dir_x`=0, go to POINT.
  - `p2_point` alone: `p2_score`+1, `serve_dir_x`=1, go to POINT.
  - Both pulses in the same frame: ignored, stay in PLAY, scores unchanged.
  - `pause_e` with no point pulse: go to PAUSED.
  - A point pulse takes priority over `pause_e` in the same frame.
- PAUSED: point pulses ignored; `pause_e` returns to PLAY; `start_e` ignored.
- POINT: load `timer`=`POINT_PAUSE`−1 on entry. At `timer`==0:
  - if either score equals `WIN_SCORE`, set `winner` and go to GAME_OVER;
  - otherwise go to SERVE.
- GAME_OVER: scores and `winner` hold. `start_e` clears both scores and `winner`, sets `serve_dir_x`=0 and goes to SERVE.
- Point pulses are ignored outside PLAY. Scores saturate at `WIN_SCORE` and never wrap.
- Outputs decoded from the registered state:
  - `ball_run`=1 only in PLAY.
  - `ball_hold_center`=1 in IDLE, SERVE, POINT and GAME_OVER.
  - `ball_hold_center`=0 in PLAY and PAUSED; in PAUSED the ball freezes in place.

## Timing
- Reset values: `state`=IDLE, scores=0, `winner`=0, `serve_dir_x`=0, `ball_run`=0, `ball_hold_center`=1, `timer`=0.
- All transitions take effect on the edge after the causing input is sampled. Decoded outputs follow `state` with no additional latency.
- Score increments on the same edge that enters POINT.
- Time spent in each timed state is exact:
  - SERVE lasts exactly `SERVE_DELAY` frames.
  - POINT lasts exactly `POINT_PAUSE` frames.
  - With parameter value 1, the state lasts one frame.
- Reset asserted in any state, including mid-countdown, returns to the reset values on that edge.
- `timer` is 8-bit and only ever counts down from a loaded value. It never wraps because exit happens at 0.

## Structure
- Shared package `pong_pkg` holds:
  - state encoding constants (3-bit), shared with the ball block;
  - `BALL_START_X`=80 and `BALL_START_Y`=75;
  - winner codes.
- Sub-module `btn_edge` (register plus AND, reset-to-1 history), instantiated twice.
- Remaining logic: one FSM block, the timer, the score registers and the output decode. Target size is about 150–250 lines.

## Test plan
- Reset, then hold `start_btn`=1 across reset release → no transition, `state`=0.
- `start_btn` 0→1 in IDLE → `state`=1 next frame. With `SERVE_DELAY`=60, `state`=2 after exactly 60 frames; `ball_hold_center` 1→0.
- In PLAY, pulse `p1_point` → `p1_score`=1, `serve_dir_x`=0, `state`=4. `POINT_PAUSE`=30 frames later, `state`=1.
- Drive `p2_point` 7 times through full serve cycles → `p2_score`=7, `winner`=2, `state`=5. Further pulses leave `p2_score`=7.
- Pause and simultaneous events:
  - `pause_e` in PLAY → `state`=3, `ball_run`=0, `ball_hold_center`=0;
  - `p1_point` while paused → ignored;
  - second `pause_e` → `state`=2;
  - `p1_point` and `p2_point` in the same frame → no score change, `state` stays 2.
- Assert `resetn`=0 mid-SERVE countdown and mid-POINT → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: match state encoding, ball start position, winner codes
// and small score/decode helpers used by the game sequencer and the ball block.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } pong_state_e;

    localparam logic [7:0] BALL_START_X = 8'd80;
    localparam logic [6:0] BALL_START_Y = 7'd75;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Scores stop at the winning score instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
        return (score < limit) ? (score + 4'd1) : score;
    endfunction

    function automatic logic hold_center(input pong_state_e s);
        logic hold;
        case (s)
            ST_PLAY:   hold = 1'b0;
            ST_PAUSED: hold = 1'b0;
            default:   hold = 1'b1;
        endcase
        return hold;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already synchronised button level. History resets
// to 1 so a button held through reset does not register a press.
module btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic rise
);

    logic btn_d;
    logic btn_q;

    assign btn_d = btn;

    // Previous-frame button level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer on the 60 Hz frame clock: match FSM, serve/point timing,
// scores, serve direction and the ball run/hold controls.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE   = 4'd7,
    parameter logic [7:0] SERVE_DELAY = 8'd60,
    parameter logic [7:0] POINT_PAUSE = 8'd30
) (
    input  logic       sixtyhz_clk,
    input  logic       resetn,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       ball_hold_center,
    output logic       serve_dir_x,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner
);

    pong_state_e state_d, state_q;
    logic [7:0]  timer_d, timer_q;
    logic [3:0]  p1_score_d, p1_score_q;
    logic [3:0]  p2_score_d, p2_score_q;
    logic [1:0]  winner_d, winner_q;
    logic        serve_dir_d, serve_dir_q;
    logic        ball_run_q, ball_hold_q;
    logic        start_e, pause_e;

    btn_edge u_start_edge (
        .clk    (sixtyhz_clk),
        .resetn (resetn),
        .btn    (start_btn),
        .rise   (start_e)
    );

    btn_edge u_pause_edge (
        .clk    (sixtyhz_clk),
        .resetn (resetn),
        .btn    (pause_btn),
        .rise   (pause_e)
    );

    // Match FSM next-state, countdown timer, scores, winner and serve direction.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_e) begin
                    p1_score_d  = 4'd0;
                    p2_score_d  = 4'd0;
                    winner_d    = WIN_NONE;
                    serve_dir_d = 1'b0;
                    timer_d     = SERVE_DELAY - 8'd1;
                    state_d     = ST_SERVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SERVE: begin
                if (timer_q == 8'd0) begin
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_PLAY: begin
                // Simultaneous point pulses cancel out; any point beats a pause press.
                if (p1_point && !p2_point) begin
                    p1_score_d  = sat_inc(p1_score_q, WIN_SCORE);
                    serve_dir_d = 1'b0;
                    timer_d     = POINT_PAUSE - 8'd1;
                    state_d     = ST_POINT;
                end else if (p2_point && !p1_point) begin
                    p2_score_d  = sat_inc(p2_score_q, WIN_SCORE);
                    serve_dir_d = 1'b1;
                    timer_d     = POINT_PAUSE - 8'd1;
                    state_d     = ST_POINT;
                end else if (!p1_point && !p2_point && pause_e) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PAUSED: begin
                if (pause_e) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_POINT: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else if (p1_score_q == WIN_SCORE) begin
                    winner_d = WIN_P1;
                    state_d  = ST_GAME_OVER;
                end else if (p2_score_q == WIN_SCORE) begin
                    winner_d = WIN_P2;
                    state_d  = ST_GAME_OVER;
                end else begin
                    timer_d = SERVE_DELAY - 8'd1;
                    state_d = ST_SERVE;
                end
            end
            default: begin
                timer_d = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and ball controls; controls are decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge sixtyhz_clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            timer_q     <= 8'd0;
            p1_score_q  <= 4'd0;
            p2_score_q  <= 4'd0;
            winner_q    <= WIN_NONE;
            serve_dir_q <= 1'b0;
            ball_run_q  <= 1'b0;
            ball_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            ball_run_q  <= (state_d == ST_PLAY);
            ball_hold_q <= hold_center(state_d);
        end
    end

    assign state            = state_q;
    assign ball_run         = ball_run_q;
    assign ball_hold_center = ball_hold_q;
    assign serve_dir_x      = serve_dir_q;
    assign p1_score         = p1_score_q;
    assign p2_score         = p2_score_q;
    assign winner           = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed match scenarios followed by
// randomized play, all compared every frame against a behavioural match model.
module tb_pong_game_ctrl;

    localparam int SD = 60;
    localparam int PP = 30;
    localparam int WS = 7;

    logic       sixtyhz_clk = 1'b0;
    logic       resetn      = 1'b0;
    logic       start_btn   = 1'b0;
    logic       pause_btn   = 1'b0;
    logic       p1_point    = 1'b0;
    logic       p2_point    = 1'b0;
    logic [2:0] state;
    logic       ball_run;
    logic       ball_hold_center;
    logic       serve_dir_x;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;

    pong_game_ctrl #(
        .WIN_SCORE   (4'd7),
        .SERVE_DELAY (8'd60),
        .POINT_PAUSE (8'd30)
    ) dut (
        .sixtyhz_clk      (sixtyhz_clk),
        .resetn           (resetn),
        .start_btn        (start_btn),
        .pause_btn        (pause_btn),
        .p1_point         (p1_point),
        .p2_point         (p2_point),
        .state            (state),
        .ball_run         (ball_run),
        .ball_hold_center (ball_hold_center),
        .serve_dir_x      (serve_dir_x),
        .p1_score         (p1_score),
        .p2_score         (p2_score),
        .winner           (winner)
    );

    always #5 sixtyhz_clk = ~sixtyhz_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Behavioural match model: phase name, frames left in the timed phase, scores.
    int m_state  = 0;
    int m_left   = 0;
    int m_p1     = 0;
    int m_p2     = 0;
    int m_win    = 0;
    int m_dir    = 0;
    bit m_prev_st = 1'b1;
    bit m_prev_sp = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic begin_match();
        m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
        m_state = 1; m_left = SD;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit p1, input bit p2, input bit rn);
        bit se, pe;
        se = st && !m_prev_st;
        pe = sp && !m_prev_sp;
        if (!rn) begin
            m_state = 0; m_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
        end else begin
            case (m_state)
                0, 5: if (se) begin_match();
                1: if (m_left <= 1) m_state = 2; else m_left--;
                2: begin
                    if (p1 && !p2) begin
                        m_p1 = (m_p1 + 1 > WS) ? WS : m_p1 + 1;
                        m_dir = 0; m_state = 4; m_left = PP;
                    end else if (p2 && !p1) begin
                        m_p2 = (m_p2 + 1 > WS) ? WS : m_p2 + 1;
                        m_dir = 1; m_state = 4; m_left = PP;
                    end else if (!p1 && !p2 && pe) begin
                        m_state = 3;
                    end
                end
                3: if (pe) m_state = 2;
                4: begin
                    if (m_left > 1) m_left--;
                    else if (m_p1 == WS) begin m_win = 1; m_state = 5; end
                    else if (m_p2 == WS) begin m_win = 2; m_state = 5; end
                    else begin m_state = 1; m_left = SD; end
                end
                default: m_state = 0;
            endcase
        end
        m_prev_st = rn ? st : 1'b1;
        m_prev_sp = rn ? sp : 1'b1;
    endtask

    // Compare every frame against the model, away from the active edge.
    always @(negedge sixtyhz_clk) begin
        if (cmp_en) begin
            chk("state", int'(state), m_state);
            chk("ball_run", int'(ball_run), (m_state == 2) ? 1 : 0);
            chk("ball_hold_center", int'(ball_hold_center), (m_state == 2 || m_state == 3) ? 0 : 1);
            chk("serve_dir_x", int'(serve_dir_x), m_dir);
            chk("p1_score", int'(p1_score), m_p1);
            chk("p2_score", int'(p2_score), m_p2);
            chk("winner", int'(winner), m_win);
        end
    end

    task automatic frame(input bit st, input bit sp, input bit p1, input bit p2, input bit rn);
        start_btn = st; pause_btn = sp; p1_point = p1; p2_point = p2; resetn = rn;
        @(posedge sixtyhz_clk);
        model_step(st, sp, p1, p2, rn);
        @(negedge sixtyhz_clk);
    endtask

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (int'(state) != target && n < budget) begin
            frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        chk("wait_state", int'(state), target);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_hold"}, int'(ball_hold_center), 1);
        chk({tag, "_run"}, int'(ball_run), 0);
        chk({tag, "_p1"}, int'(p1_score), 0);
        chk({tag, "_p2"}, int'(p2_score), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_dir"}, int'(serve_dir_x), 0);
    endtask

    initial begin
        int cnt;
        bit r_st, r_sp;

        // Reset with start held; releasing reset must not count as a press.
        repeat (3) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        reset_literals("reset");
        repeat (2) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("held_start_state", int'(state), 0);

        // Start press and exact serve length.
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("start_state", int'(state), 1);
        chk("serve_hold", int'(ball_hold_center), 1);
        cnt = 0;
        while (int'(state) == 1 && cnt < 200) begin
            cnt++;
            frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("serve_frames", cnt, 60);
        chk("play_state", int'(state), 2);
        chk("play_hold", int'(ball_hold_center), 0);
        chk("play_run", int'(ball_run), 1);

        // p1 point and exact point pause.
        frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("p1pt_score", int'(p1_score), 1);
        chk("p1pt_dir", int'(serve_dir_x), 0);
        chk("p1pt_state", int'(state), 4);
        cnt = 0;
        while (int'(state) == 4 && cnt < 200) begin
            cnt++;
            frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("point_frames", cnt, 30);
        chk("after_point_state", int'(state), 1);

        // Pause, ignored point while paused, resume, simultaneous points.
        wait_state(2, 200);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("paused_state", int'(state), 3);
        chk("paused_run", int'(ball_run), 0);
        chk("paused_hold", int'(ball_hold_center), 0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("paused_p1", int'(p1_score), 1);
        chk("paused_keep", int'(state), 3);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("resume_state", int'(state), 2);
        frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("both_p1", int'(p1_score), 1);
        chk("both_p2", int'(p2_score), 0);
        chk("both_state", int'(state), 2);

        // p2 wins 7 points; further pulses do nothing.
        for (int i = 0; i < 7; i++) begin
            wait_state(2, 200);
            frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("p2pt_dir", int'(serve_dir_x), 1);
        end
        wait_state(5, 200);
        chk("win_p2", int'(p2_score), 7);
        chk("win_code", int'(winner), 2);
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("over_p2_sat", int'(p2_score), 7);
        chk("over_state", int'(state), 5);

        // Reset mid-SERVE countdown.
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_state", int'(state), 1);
        chk("restart_p2", int'(p2_score), 0);
        repeat (5) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_literals("rst_serve");

        // Reset mid-POINT countdown.
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_state(2, 200);
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_point", int'(state), 4);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_literals("rst_point");

        // Randomized play against the model.
        r_st = 1'b0;
        r_sp = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 9) == 0) r_st = ~r_st;
            if ($urandom_range(0, 14) == 0) r_sp = ~r_sp;
            frame(r_st, r_sp,
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 1499) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
